// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_pkg;

  // Largest supported number of register slices in one chain.
  localparam int unsigned MAX_DEPTH = 8;

  // Bubble control encoding: every control bit deasserted.
  localparam logic BUBBLE_CTRL_BIT = 1'b0;

  // Working width for the saturating counter helper.
  localparam int unsigned SAT_W = 64;

  // Increment v unless it already equals max_v.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v == max_v) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One register slice of the chain: bubble, hold or load from its source.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{BUBBLE_CTRL_BIT}};

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next-state select; bubble outranks hold, hold outranks load.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (bubble) begin
      valid_d = 1'b0;
      ctrl_d  = BUBBLE_CTRL;
      if (CLEAR_DATA != 0) data_d = '0;
    end else if (!hold) begin
      valid_d = src_valid;
      ctrl_d  = src_valid ? src_ctrl : BUBBLE_CTRL;
      data_d  = (src_valid || (CLEAR_DATA == 0)) ? src_data : '0;
    end
  end

  // Slice state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Multi-slice pipeline register chain with stall/flush and occupancy counters.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEPTH-1:0]  stall,
  input  logic [DEPTH-1:0]  flush,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [CNT_W-1:0]  valid_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH out of range");
  end

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic [DEPTH-1:0]  hold_c;
  logic [DEPTH-1:0]  bubble_c;
  logic [DEPTH-1:0]  slice_valid;
  logic [CTRL_W-1:0] slice_ctrl [DEPTH];
  logic [DATA_W-1:0] slice_data [DEPTH];

  logic [CNT_W-1:0]  valid_cnt_q,  valid_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  // Effective hold: a stall anywhere downstream freezes this slice too.
  always_comb begin
    hold_c = '0;
    hold_c[DEPTH-1] = stall[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      hold_c[i] = stall[i] | hold_c[i+1];
    end
  end

  // Bubble on flush, or when the upstream slice holds while this one advances.
  always_comb begin
    bubble_c = '0;
    bubble_c[0] = flush[0];
    for (int i = 1; i < int'(DEPTH); i++) begin
      bubble_c[i] = flush[i] | (hold_c[i-1] & ~hold_c[i]);
    end
  end

  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_slice
    logic              src_valid;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;

    if (gi == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_ctrl  = in_ctrl;
      assign src_data  = in_data;
    end else begin : g_src_prev
      assign src_valid = slice_valid[gi-1];
      assign src_ctrl  = slice_ctrl[gi-1];
      assign src_data  = slice_data[gi-1];
    end

    pipe_slice #(
      .CTRL_W     (CTRL_W),
      .DATA_W     (DATA_W),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_slice (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold_c[gi]),
      .bubble    (bubble_c[gi]),
      .src_valid (src_valid),
      .src_ctrl  (src_ctrl),
      .src_data  (src_data),
      .valid     (slice_valid[gi]),
      .ctrl      (slice_ctrl[gi]),
      .data      (slice_data[gi])
    );
  end

  // Counter next state from the registered output slice; clear beats increment.
  always_comb begin
    valid_cnt_d  = valid_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      valid_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (slice_valid[DEPTH-1] && !stall[DEPTH-1]) begin
        valid_cnt_d = CNT_W'(sat_inc(SAT_W'(valid_cnt_q), CNT_MAX));
      end
      if (!slice_valid[DEPTH-1]) begin
        bubble_cnt_d = CNT_W'(sat_inc(SAT_W'(bubble_cnt_q), CNT_MAX));
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_cnt_q  <= valid_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid   = slice_valid[DEPTH-1];
  assign out_ctrl    = slice_ctrl[DEPTH-1];
  assign out_data    = slice_data[DEPTH-1];
  assign stage_valid = slice_valid;
  assign valid_cnt   = valid_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule
